game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter GRAV_TICKS, default 16, clka cycles between gravity drop requests while in MOVE (legal range 2..255).
REQ-002 clka  input  1  sole clock; all state updates on rising edge.
REQ-003 restart_n  input  1  reset, asynchronous assert and active-low; deassertion is synchronous to clka.
REQ-004 btn_left / btn_right / btn_rotate  input  1 each  level-sensitive player buttons, already synchronised to clka.
REQ-005 touched  input  1  datapath flag: active piece has landed.
REQ-006 error  input  1  datapath flag: spawn collided, game lost.
REQ-007 board_in  input  32  current board: 8 rows x 4 columns; row r = board_in[4r+3:4r]; row 7 is the top.
REQ-008 state  output  3  phase to datapath: NEWBOARD=3'b100, GEN=3'b000, MOVE=3'b001, LAND=3'b010, CLEAR=3'b011, GAMEOVER=3'b101.
REQ-009 move  output  2  0=left, 1=right, 2=rotate, 3=drop; meaningful only while move_valid=1.
REQ-010 move_valid  output  1  single-cycle move request strobe.
REQ-011 score  output  8  lines cleared since last NEWBOARD.

Function
REQ-012 Button edges: a 0->1 transition is sampled on each button; if several rise in one cycle, priority is rotate > left > right; lower-priority edges in that cycle are dropped.
REQ-013 One-deep pending-request register: holds one button request (move code + valid); a newer edge overwrites an un-issued request.
REQ-014 NEWBOARD lasts exactly 1 cycle, then GEN; score cleared to 0; pending request cleared.
REQ-015 GEN lasts exactly 1 cycle; next state GAMEOVER if error=1 in that cycle, else MOVE.
REQ-016 On entry to MOVE, gravity counter loads 0; it increments each MOVE cycle; when it reaches GRAV_TICKS-1 it wraps to 0 and a drop request (move=3) is generated that cycle.
REQ-017 In MOVE, at most one move_valid per cycle: drop request wins over a pending button request; the button request stays pending and issues the next cycle.
REQ-018 In MOVE, touched=1 forces next state LAND; move_valid=0 that cycle; pending request is discarded.
REQ-019 Button edges arriving outside MOVE are discarded (except REQ-022).
REQ-020 LAND lasts exactly 1 cycle, then CLEAR.
REQ-021 CLEAR lasts exactly 1 cycle: count rows with all 4 bits set in board_in (0..8), add to score saturating at 255; next state GEN.
REQ-022 GAMEOVER holds indefinitely; a btn_rotate rising edge moves to NEWBOARD next cycle; move_valid stays 0.
REQ-023 state, move, move_valid, score are registered outputs (no combinational path from inputs).

Reset
REQ-024 While restart_n=0: state=NEWBOARD, move=0, move_valid=0, score=0, gravity counter=0, pending request cleared, button edge history=0.
REQ-025 Reset asserted mid-MOVE or mid-CLEAR abandons the operation; no partial score update survives.
REQ-026 First active edge after release executes NEWBOARD (1 cycle) then GEN.

Configuration
REQ-027 Macro GAME_CTRL_SCORE_EN: when defined, score counter and row-full detection are built per REQ-021; when undefined, score is tied to 8'd0, no row-count logic exists, CLEAR still lasts 1 cycle.

Verification (GRAV_TICKS=4)
REQ-028 Release reset, error=0 -> state sequence NEWBOARD, GEN, MOVE on cycles 1,2,3; move_valid=0 throughout.
REQ-029 Stay in MOVE, no buttons -> move_valid with move=3 every 4th MOVE cycle (MOVE cycles 4, 8, 12).
REQ-030 btn_left rising edge in the same cycle as a drop request -> move=3 strobe that cycle, move=0 strobe next cycle.
REQ-031 touched=1 in MOVE with board_in=32'h0000_F0FF -> LAND, CLEAR, GEN; score increments by 3 (rows 0,1,3 full).
REQ-032 error=1 in GEN -> GAMEOVER held for 50 cycles with btn_left/right pulsed; btn_rotate edge -> NEWBOARD, score=0.
REQ-033 restart_n pulled low mid-MOVE asynchronously -> outputs at reset values before next clka edge; with GAME_CTRL_SCORE_EN undefined, REQ-031 stimulus leaves score=0.

Source files
------------

// File: rtl/game_ctrl.sv
// Falling-block game phase controller: sequences board phases, turns button edges and
// gravity ticks into move requests, and keeps the score (scoring built only with GAME_CTRL_SCORE_EN).
module game_ctrl #(
    parameter int unsigned GRAV_TICKS = 16
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        touched,
    input  logic        error,
    input  logic [31:0] board_in,
    output logic [2:0]  state,
    output logic [1:0]  move,
    output logic        move_valid,
    output logic [7:0]  score
);

    typedef enum logic [2:0] {
        GEN      = 3'b000,
        MOVE     = 3'b001,
        LAND     = 3'b010,
        CLEAR    = 3'b011,
        NEWBOARD = 3'b100,
        GAMEOVER = 3'b101
    } state_t;

    localparam logic [7:0] GRAV_LAST = 8'(GRAV_TICKS - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] grav_cnt;
    logic [7:0] grav_next;
    logic [7:0] grav_inc;
    logic       pend_valid;
    logic       pend_valid_next;
    logic [1:0] pend_code;
    logic [1:0] pend_code_next;
    logic [1:0] move_next;
    logic       move_valid_next;
    logic [2:0] btn_now;
    logic [2:0] btn_prev;
    logic [2:0] rise;
    logic       edge_any;
    logic [1:0] edge_code;
    logic       req_valid;
    logic [1:0] req_code;

    assign btn_now  = {btn_rotate, btn_left, btn_right};
    assign rise     = btn_now & ~btn_prev;
    assign edge_any = |rise;
    assign grav_inc = (grav_cnt == GRAV_LAST) ? 8'd0 : grav_cnt + 8'd1;

    // A fresh edge always replaces whatever request is still waiting.
    assign req_valid = pend_valid | edge_any;
    assign req_code  = edge_any ? edge_code : pend_code;

    always_comb begin
        edge_code = 2'd0;
        if (rise[2]) begin
            edge_code = 2'd2;
        end else if (rise[1]) begin
            edge_code = 2'd0;
        end else if (rise[0]) begin
            edge_code = 2'd1;
        end
    end

    always_comb begin
        next_state      = cur_state;
        grav_next       = grav_cnt;
        pend_valid_next = 1'b0;
        pend_code_next  = 2'd0;
        move_next       = 2'd0;
        move_valid_next = 1'b0;
        case (cur_state)
            NEWBOARD: next_state = GEN;
            GEN: begin
                next_state = error ? GAMEOVER : MOVE;
                grav_next  = 8'd0;
            end
            MOVE: begin
                if (touched) begin
                    next_state = LAND;
                    grav_next  = 8'd0;
                end else begin
                    grav_next = grav_inc;
                    // Gravity owns the strobe slot; a button request waits one more cycle.
                    if (grav_inc == GRAV_LAST) begin
                        move_valid_next = 1'b1;
                        move_next       = 2'd3;
                        pend_valid_next = req_valid;
                        pend_code_next  = req_code;
                    end else if (req_valid) begin
                        move_valid_next = 1'b1;
                        move_next       = req_code;
                    end
                end
            end
            LAND:     next_state = CLEAR;
            CLEAR:    next_state = GEN;
            GAMEOVER: if (rise[2]) next_state = NEWBOARD;
            default:  next_state = NEWBOARD;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            cur_state  <= NEWBOARD;
            grav_cnt   <= 8'd0;
            pend_valid <= 1'b0;
            pend_code  <= 2'd0;
            move       <= 2'd0;
            move_valid <= 1'b0;
            btn_prev   <= 3'd0;
        end else begin
            cur_state  <= next_state;
            grav_cnt   <= grav_next;
            pend_valid <= pend_valid_next;
            pend_code  <= pend_code_next;
            move       <= move_next;
            move_valid <= move_valid_next;
            btn_prev   <= btn_now;
        end
    end

    assign state = cur_state;

`ifdef GAME_CTRL_SCORE_EN
    logic [3:0] full_rows;
    logic [8:0] score_sum;
    logic [7:0] score_q;

    always_comb begin
        full_rows = 4'd0;
        for (int r = 0; r < 8; r++) begin
            if (&board_in[4*r +: 4]) begin
                full_rows = full_rows + 4'd1;
            end
        end
    end

    assign score_sum = {1'b0, score_q} + {5'd0, full_rows};

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            score_q <= 8'd0;
        end else if (next_state == NEWBOARD) begin
            score_q <= 8'd0;
        end else if (cur_state == CLEAR) begin
            score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
        end
    end

    assign score = score_q;
`else
    logic unused_board;
    assign unused_board = ^board_in;
    assign score        = 8'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl (GRAV_TICKS=4): a cycle model built from the game rules runs
// alongside the DUT and is compared every falling edge, plus literal checkpoints.
module tb_game_ctrl;

    localparam int GT = 4;
    localparam logic [2:0] S_NB   = 3'b100;
    localparam logic [2:0] S_GEN  = 3'b000;
    localparam logic [2:0] S_MV   = 3'b001;
    localparam logic [2:0] S_LAND = 3'b010;
    localparam logic [2:0] S_CLR  = 3'b011;
    localparam logic [2:0] S_GO   = 3'b101;
`ifdef GAME_CTRL_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        restart_n;
    logic        btn_left, btn_right, btn_rotate, touched, error;
    logic [31:0] board_in;
    logic [2:0]  state;
    logic [1:0]  move;
    logic        move_valid;
    logic [7:0]  score;

    int n_checks = 0;
    int n_pass   = 0;

    game_ctrl #(.GRAV_TICKS(GT)) dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_rotate (btn_rotate),
        .touched    (touched),
        .error      (error),
        .board_in   (board_in),
        .state      (state),
        .move       (move),
        .move_valid (move_valid),
        .score      (score)
    );

    always #5 clka = ~clka;

    // Rule model: m_k is the 1-based index of the MOVE cycle being entered; drops land on multiples of GT.
    logic [2:0] m_state = S_NB;
    int         m_k     = 0;
    int         m_q[$];
    int         m_score = 0;
    int         m_code  = 0;
    int         m_rows  = 0;
    logic [1:0] m_move  = 2'd0;
    logic       m_valid = 1'b0;
    logic [2:0] m_prev  = 3'd0;
    logic [2:0] m_rise  = 3'd0;
    logic [2:0] m_next  = S_NB;

    always @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            m_state = S_NB;
            m_k     = 0;
            m_q.delete();
            m_score = 0;
            m_move  = 2'd0;
            m_valid = 1'b0;
            m_prev  = 3'd0;
        end else begin
            m_rise  = {btn_rotate, btn_left, btn_right} & ~m_prev;
            m_prev  = {btn_rotate, btn_left, btn_right};
            m_code  = m_rise[2] ? 2 : (m_rise[1] ? 0 : 1);
            m_valid = 1'b0;
            m_move  = 2'd0;
            m_next  = m_state;
            case (m_state)
                S_NB: m_next = S_GEN;
                S_GEN: begin
                    m_next = error ? S_GO : S_MV;
                    m_k    = 1;
                end
                S_MV: begin
                    if (touched) begin
                        m_next = S_LAND;
                        m_q.delete();
                    end else begin
                        m_k++;
                        if (m_rise != 3'd0) begin
                            m_q.delete();
                            m_q.push_back(m_code);
                        end
                        if (m_k % GT == 0) begin
                            m_valid = 1'b1;
                            m_move  = 2'd3;
                        end else if (m_q.size() > 0) begin
                            m_valid = 1'b1;
                            m_move  = 2'(m_q.pop_front());
                        end
                    end
                end
                S_LAND: m_next = S_CLR;
                S_CLR: begin
                    m_next = S_GEN;
                    if (SCORE_ON) begin
                        m_rows = 0;
                        for (int r = 0; r < 8; r++) begin
                            if (board_in[4*r +: 4] == 4'hF) m_rows++;
                        end
                        m_score = (m_score + m_rows > 255) ? 255 : m_score + m_rows;
                    end
                end
                S_GO: if (m_rise[2]) m_next = S_NB;
                default: m_next = S_NB;
            endcase
            if (m_next == S_NB) m_score = 0;
            m_state = m_next;
        end
    end

    task automatic compare(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clka) begin
        compare("cycle.state", int'(state), int'(m_state));
        compare("cycle.move_valid", int'(move_valid), int'(m_valid));
        compare("cycle.move", int'(move), int'(m_move));
        compare("cycle.score", int'(score), m_score);
    end

    task automatic checkOutput(input string name, input logic [2:0] es, input logic ev,
                               input logic [1:0] em, input int esc);
        compare({name, ".state"}, int'(state), int'(es));
        compare({name, ".move_valid"}, int'(move_valid), int'(ev));
        compare({name, ".move"}, int'(move), int'(em));
        compare({name, ".score"}, int'(score), esc);
        compare({name, ".model_state"}, int'(m_state), int'(es));
        compare({name, ".model_score"}, m_score, esc);
    endtask

    // Inputs change 1 time unit after a rising edge and hold for n cycles.
    task automatic applyStimulus(input logic l, input logic r, input logic rot, input logic t,
                                 input logic e, input logic [31:0] b, input int n);
        btn_left   = l;
        btn_right  = r;
        btn_rotate = rot;
        touched    = t;
        error      = e;
        board_in   = b;
        repeat (n) @(posedge clka);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc;
        restart_n  = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_rotate = 1'b0;
        touched    = 1'b0;
        error      = 1'b0;
        board_in   = 32'd0;
        repeat (3) @(posedge clka);
        #1;
        checkOutput("reset", S_NB, 1'b0, 2'd0, 0);
        restart_n = 1'b1;
        checkOutput("cycle1_newboard", S_NB, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("cycle2_gen", S_GEN, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("cycle3_move", S_MV, 1'b0, 2'd0, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'd0, 3);
        checkOutput("drop_k4", S_MV, 1'b1, 2'd3, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("idle_k5", S_MV, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 3);
        checkOutput("drop_k8", S_MV, 1'b1, 2'd3, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 4);
        checkOutput("drop_k12", S_MV, 1'b1, 2'd3, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'd0, 3);
        applyStimulus(1, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("left_vs_drop_drop", S_MV, 1'b1, 2'd3, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("left_vs_drop_left", S_MV, 1'b1, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("after_left_idle", S_MV, 1'b0, 2'd0, 0);

        applyStimulus(1, 0, 1, 0, 0, 32'd0, 1);
        checkOutput("rotate_priority", S_MV, 1'b1, 2'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("drop_k20", S_MV, 1'b1, 2'd3, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("left_dropped", S_MV, 1'b0, 2'd0, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'd0, 2);
        applyStimulus(0, 1, 0, 0, 0, 32'd0, 1);
        checkOutput("right_held_by_drop", S_MV, 1'b1, 2'd3, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("left_overwrites_right", S_MV, 1'b1, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("no_stale_right", S_MV, 1'b0, 2'd0, 0);

        applyStimulus(0, 0, 0, 1, 0, 32'h0000_F0FF, 1);
        checkOutput("land", S_LAND, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0000_F0FF, 1);
        checkOutput("clear", S_CLR, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0000_F0FF, 1);
        sc = SCORE_ON ? 3 : 0;
        checkOutput("score_three_rows", S_GEN, 1'b0, 2'd0, sc);

        for (int i = 0; i < 33; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
            applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
            applyStimulus(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2);
        end
        sc = SCORE_ON ? 255 : 0;
        checkOutput("score_saturated", S_GEN, 1'b0, 2'd0, sc);

        applyStimulus(0, 0, 0, 0, 1, 32'd0, 1);
        checkOutput("gameover_entry", S_GO, 1'b0, 2'd0, sc);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(i % 2 == 0, i % 2 == 1, 0, 0, 0, 32'd0, 1);
        end
        checkOutput("gameover_held", S_GO, 1'b0, 2'd0, sc);
        applyStimulus(0, 0, 1, 0, 0, 32'd0, 1);
        checkOutput("restart_newboard", S_NB, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 2);
        checkOutput("restart_move", S_MV, 1'b0, 2'd0, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        #2;
        restart_n = 1'b0;
        #1;
        checkOutput("async_reset_move", S_NB, 1'b0, 2'd0, 0);
        @(posedge clka);
        #1;
        restart_n = 1'b1;
        checkOutput("release_newboard", S_NB, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 1);
        checkOutput("release_gen", S_GEN, 1'b0, 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        checkOutput("clear_before_reset", S_CLR, 1'b0, 2'd0, 0);
        #2;
        restart_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", S_NB, 1'b0, 2'd0, 0);
        @(posedge clka);
        #1;
        restart_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        checkOutput("no_partial_score", S_GEN, 1'b0, 2'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
